// File: rtl/restoring_divider_pkg.sv
// restoring_divider_pkg: shared FSM state type and counter sizing for the restoring divider
package restoring_divider_pkg;
  typedef enum logic [1:0] {IDLE, DIVIDE, ZERO, DONE} state_t;
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/restoring_divider_if.sv
// restoring_divider_if: start/done handshake, operands and results of the divider
interface restoring_divider_if #(parameter int NUM_BITS = 8);
  logic                start;
  logic [NUM_BITS-1:0] dividend;
  logic [NUM_BITS-1:0] divisor;
  logic                busy;
  logic                done;
  logic [NUM_BITS-1:0] quotient;
  logic [NUM_BITS-1:0] remainder;
  logic                div_by_zero;
  modport master(output start, dividend, divisor, input busy, done, quotient, remainder, div_by_zero);
  modport slave(input start, dividend, divisor, output busy, done, quotient, remainder, div_by_zero);
endinterface

// File: rtl/restoring_divider_subtractor.sv
// subtractor_nbit: combinational a-b as a ripple of 1-bit full subtractors
module subtractor_nbit #(parameter int NUM_BITS = 8) (
  input  logic [NUM_BITS-1:0] a,
  input  logic [NUM_BITS-1:0] b,
  output logic [NUM_BITS-1:0] diff,
  output logic                borrow_out
);
  logic [NUM_BITS:0] w_borrow;
  assign w_borrow[0] = 1'b0;
  for (genvar i = 0; i < NUM_BITS; i++) begin : g_fs
    assign diff[i]         = a[i] ^ b[i] ^ w_borrow[i];
    assign w_borrow[i + 1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & w_borrow[i]);
  end
  assign borrow_out = w_borrow[NUM_BITS];
endmodule

// File: rtl/restoring_divider.sv
// restoring_divider: multi-cycle shift-and-subtract divider, one quotient bit per clock.
// Define RESTORING_DIVIDER_SIGNED_EN for two's-complement truncating division.
module restoring_divider import restoring_divider_pkg::*; #(parameter int NUM_BITS = 8) (
  input logic               clk,
  input logic               rst,
  restoring_divider_if.slave bus
);
  localparam int CNT_W = cnt_width(NUM_BITS);
  state_t              r_state, w_state;
  logic [CNT_W-1:0]    r_cnt, w_cnt;
  logic [NUM_BITS-1:0] r_quo, w_quo, r_rem, w_rem, r_dvs, w_dvs;
  logic [NUM_BITS-1:0] w_partial, w_trial, w_q_iter, w_r_iter;
  logic                r_dbz, w_dbz, w_borrow;
`ifdef RESTORING_DIVIDER_SIGNED_EN
  logic                r_neg_q, w_neg_q, r_neg_r, w_neg_r;
  function automatic logic [NUM_BITS-1:0] mag(input logic [NUM_BITS-1:0] x);
    return x[NUM_BITS-1] ? -x : x;
  endfunction
`endif
  // Remainder stays below 2^k after k steps, so dropping its MSB never loses data
  assign w_partial = {r_rem[NUM_BITS-2:0], r_quo[NUM_BITS-1]};
  subtractor_nbit #(.NUM_BITS(NUM_BITS)) u_sub (
    .a(w_partial), .b(r_dvs), .diff(w_trial), .borrow_out(w_borrow)
  );
  assign w_q_iter = {r_quo[NUM_BITS-2:0], ~w_borrow};
  assign w_r_iter = w_borrow ? w_partial : w_trial;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_quo   <= '0;
      r_rem   <= '0;
      r_dvs   <= '0;
      r_dbz   <= 1'b0;
`ifdef RESTORING_DIVIDER_SIGNED_EN
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
`endif
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_quo   <= w_quo;
      r_rem   <= w_rem;
      r_dvs   <= w_dvs;
      r_dbz   <= w_dbz;
`ifdef RESTORING_DIVIDER_SIGNED_EN
      r_neg_q <= w_neg_q;
      r_neg_r <= w_neg_r;
`endif
    end
  end
  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_quo   = r_quo;
    w_rem   = r_rem;
    w_dvs   = r_dvs;
    w_dbz   = r_dbz;
`ifdef RESTORING_DIVIDER_SIGNED_EN
    w_neg_q = r_neg_q;
    w_neg_r = r_neg_r;
`endif
    case (r_state)
      IDLE: if (bus.start) begin
        w_state = (bus.divisor == '0) ? ZERO : DIVIDE;
        w_cnt   = '0;
        w_rem   = '0;
        w_dbz   = 1'b0;
`ifdef RESTORING_DIVIDER_SIGNED_EN
        w_quo   = mag(bus.dividend);
        w_dvs   = mag(bus.divisor);
        w_neg_q = bus.dividend[NUM_BITS-1] ^ bus.divisor[NUM_BITS-1];
        w_neg_r = bus.dividend[NUM_BITS-1];
`else
        w_quo   = bus.dividend;
        w_dvs   = bus.divisor;
`endif
      end
      DIVIDE: begin
        w_cnt = r_cnt + 1'b1;
        w_quo = w_q_iter;
        w_rem = w_r_iter;
        if (r_cnt == CNT_W'(NUM_BITS - 1)) begin
          w_state = DONE;
`ifdef RESTORING_DIVIDER_SIGNED_EN
          w_quo   = r_neg_q ? -w_q_iter : w_q_iter;
          w_rem   = r_neg_r ? -w_r_iter : w_r_iter;
`endif
        end
      end
      ZERO: begin
        w_state = DONE;
        w_quo   = '1;
        w_dbz   = 1'b1;
`ifdef RESTORING_DIVIDER_SIGNED_EN
        w_rem   = r_neg_r ? -r_quo : r_quo;
`else
        w_rem   = r_quo;
`endif
      end
      DONE:    w_state = IDLE;
      default: w_state = IDLE;
    endcase
  end
  assign bus.busy        = (r_state == DIVIDE) || (r_state == ZERO);
  assign bus.done        = (r_state == DONE);
  assign bus.quotient    = r_quo;
  assign bus.remainder   = r_rem;
  assign bus.div_by_zero = r_dbz;
endmodule

// File: doc/restoring_divider.md
Name: restoring_divider

Overview:
- Multi-cycle unsigned integer divider using shift-and-subtract (restoring) division, one quotient bit per clock.
- Performs the inverse arithmetic of the team's ripple adders.
- Serves as the shared divide resource for datapath blocks that cannot afford a combinational divider.
- Uses a start/done handshake; results are held until the next accepted start.

Parameters:
- NUM_BITS, 8, width of dividend, divisor, quotient and remainder (legal range 2 to 32).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- start  input  1  request a division; sampled only in IDLE.
- dividend  input  NUM_BITS  numerator; captured on accepted start.
- divisor  input  NUM_BITS  denominator; captured on accepted start.
- busy  output  1  high from accepted start through the cycle before done.
- done  output  1  one-cycle pulse; quotient/remainder valid from this cycle onward.
- quotient  output  NUM_BITS  registered result.
- remainder  output  NUM_BITS  registered result.
- div_by_zero  output  1  high with done when the captured divisor was 0; held until next accepted start.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; busy=0, done=0, div_by_zero=0, quotient=0, remainder=0, iteration counter=0. A reset mid-division discards the operation, and no done is produced.
- States and transitions:
  - IDLE: start=1 captures operands, clears div_by_zero, and loads the quotient register with the dividend and the remainder register with 0. Go to DIVIDE, or to ZERO if divisor==0.
  - DIVIDE: each cycle forms partial={remainder[NUM_BITS-2:0], quotient[NUM_BITS-1]} and shifts quotient left. It computes trial=partial-divisor using the sub-module.
    - No borrow: remainder=trial and new quotient LSB=1.
    - Borrow: remainder=partial and new quotient LSB=0.
    - After exactly NUM_BITS iterations go to DONE.
  - ZERO: quotient=all ones, remainder=dividend, div_by_zero=1. Go to DONE.
  - DONE: done=1 for this single cycle, busy=0. Go to IDLE.
- Latency: if start is sampled at edge E0, done is high in the cycle after edge E(NUM_BITS); for a zero divisor, in the cycle after E1.
- busy=1 in DIVIDE and ZERO only.
- start while busy or during DONE is ignored (not queued). start held high continuously launches back-to-back divisions, with one IDLE cycle between done and the next capture.
- Operand inputs may change freely after capture without affecting the result.
- Outputs hold their last result through IDLE. They change only after the next accepted start, and intermediate values are visible while busy.
- Divisor > dividend gives quotient=0, remainder=dividend. Dividend=0 gives 0/0 remainder.

Optional Feature:
- Macro: RESTORING_DIVIDER_SIGNED_EN.
- Defined:
  - Operands are two's complement. Magnitudes are taken at capture and the magnitude division is unchanged.
  - On the DONE transition, quotient is negated if the operand signs differ, and remainder takes the sign of the dividend (truncating division).
  - Most-negative / -1 returns quotient=most-negative, remainder=0.
  - Divide-by-zero returns quotient=-1 and remainder=dividend.
  - Latency is unchanged.
- Undefined: purely unsigned behaviour as above.

Decomposition:
- Package restoring_divider_pkg holds:
  - the state enum (IDLE, DIVIDE, ZERO, DONE);
  - a localparam for counter width = $clog2(NUM_BITS+1).
- Sub-module subtractor_nbit (parameter NUM_BITS; ports a, b, diff, borrow_out) is combinational a-b. It is built as a ripple of 1-bit full subtractors, mirroring the adder structure. It is instantiated once for the trial subtraction.

Test Plan:
- Reset with rst high mid-DIVIDE at cycle 4 -> all outputs 0, state IDLE, no done pulse. A following start works normally.
- dividend=100, divisor=7 -> done high 8 cycles after start sampled; quotient=14, remainder=2; busy high for exactly 8 cycles.
- dividend=5, divisor=200 -> quotient=0, remainder=5.
- dividend=255, divisor=1 -> quotient=255, remainder=0.
- dividend=42, divisor=0 -> done 1 cycle after start; quotient=8'hFF, remainder=42, div_by_zero=1, cleared on next accepted start.
- Pulse start again on cycles 2 and 5 during a 200/3 division -> ignored; quotient=66, remainder=2. With SIGNED_EN, -100/7 -> quotient=-14, remainder=-2.
